// File: rtl/nn_readback_bank.sv
// Host-visible readback bank: snapshots datapath results on ListoIn rising edge and serves
// them through a 1-cycle registered read port with sticky ready/error/overrun flags.
module nn_readback_bank #(
  parameter int Width     = 4,
  parameter int NumCoeff  = 20,
  parameter int NumY      = 10,
  parameter int AddrWidth = 9
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      ListoIn,
  input  logic                      InError,
  input  logic [Width-1:0]          InDato,
  input  logic [NumCoeff*Width-1:0] Coeff,
  input  logic [Width-1:0]          Offset,
  input  logic [Width-1:0]          DatoEntradaSistema,
  input  logic [NumY*Width-1:0]     Y,
  input  logic                      Read,
  input  logic [AddrWidth-1:0]      Address,
  output logic [Width-1:0]          OutDato,
  output logic                      ReadValid,
  output logic                      AddrErr
);

  localparam int IdxW       = AddrWidth - 2;
  localparam int NumWords   = 5 + NumCoeff + NumY;
  localparam int WordErr    = 2;
  localparam int WordCoeff  = 3;
  localparam int WordOffset = 3 + NumCoeff;
  localparam int WordDse    = 4 + NumCoeff;
  localparam int WordY      = 5 + NumCoeff;

  logic             listo_q;
  logic             rdy_flag;
  logic             err_flag;
  logic             ovr_flag;
  logic [Width-1:0] dato_s;
  logic [Width-1:0] offset_s;
  logic [Width-1:0] dse_s;
  logic [Width-1:0] coeff_s [NumCoeff];
  logic [Width-1:0] y_s     [NumY];
  logic [Width-1:0] words   [NumWords];
  logic [Width-1:0] status_word;
  logic [Width-1:0] err_word;
  logic [Width-1:0] rd_word;
  logic [IdxW-1:0]  word_idx;
  logic             rise;
  logic             in_map;
  logic             hit;
  logic             rd_status;
  logic             rd_err;

  assign rise      = ListoIn & ~listo_q;
  assign word_idx  = Address[AddrWidth-1:2];
  assign in_map    = {1'b0, word_idx} < (IdxW+1)'(NumWords);
  assign hit       = Read & (Address[1:0] == 2'b00) & in_map;
  assign rd_status = hit & (word_idx == '0);
  assign rd_err    = hit & (word_idx == IdxW'(WordErr));

  always_comb begin
    status_word      = '0;
    status_word[2:0] = {ovr_flag, err_flag, rdy_flag};
    err_word         = '0;
    err_word[0]      = err_flag;
  end

  // Flat word table in address order; index = byte address / 4.
  assign words[0]          = status_word;
  assign words[1]          = dato_s;
  assign words[WordErr]    = err_word;
  assign words[WordOffset] = offset_s;
  assign words[WordDse]    = dse_s;

  generate
    for (genvar gi = 0; gi < NumCoeff; gi++) begin : g_coeff
      assign words[WordCoeff+gi] = coeff_s[gi];
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  coeff_s[gi] <= '0;
        else if (rise) coeff_s[gi] <= Coeff[gi*Width +: Width];
      end
    end
    for (genvar gi = 0; gi < NumY; gi++) begin : g_y
      assign words[WordY+gi] = y_s[gi];
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  y_s[gi] <= '0;
        else if (rise) y_s[gi] <= Y[gi*Width +: Width];
      end
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (word_idx == IdxW'(k)) rd_word = words[k];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      listo_q  <= 1'b0;
      dato_s   <= '0;
      offset_s <= '0;
      dse_s    <= '0;
    end else begin
      listo_q <= ListoIn;
      if (rise) begin
        dato_s   <= InDato;
        offset_s <= Offset;
        dse_s    <= DatoEntradaSistema;
      end
    end
  end

  // Sets take priority over clear-on-read so no event is lost in a collision.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdy_flag <= 1'b0;
      ovr_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      if (rise)           rdy_flag <= 1'b1;
      else if (rd_status) rdy_flag <= 1'b0;

      if (rise && rdy_flag) ovr_flag <= 1'b1;
      else if (rd_status)   ovr_flag <= 1'b0;

      if (InError)     err_flag <= 1'b1;
      else if (rd_err) err_flag <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ReadValid <= 1'b0;
      AddrErr   <= 1'b0;
      OutDato   <= '0;
    end else begin
      ReadValid <= Read;
      AddrErr   <= Read & ~hit;
      OutDato   <= hit ? rd_word : '0;
    end
  end

endmodule
